e_muldiv: RTL and testbench
===========================

Name: e_muldiv

Overview:
- Execute-stage multiply/divide unit that owns the HI and LO registers.
- Runs MULT/MULTU/DIV/DIVU as multi-cycle operations and asserts busy so the hazard logic stalls the pipeline.
- Performs MTHI/MTLO writes.
- Produces the hilo read value that the decode-stage forwarding mux consumes for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU (must be at least 1).
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU (must be at least 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch the operation encoded on md_op this cycle.
- md_op  in  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- a  in  32  rs operand.
- b  in  32  rt operand.
- hilo_sel  in  2  read select: 0 none, 1 HI, 2 LO, 3 none.
- busy  out  1  a multi-cycle operation is in flight.
- hi  out  32  current HI register.
- lo  out  32  current LO register.
- hilo_rd  out  32  combinational read: HI if hilo_sel=1, LO if hilo_sel=2, else 0.

Behaviour:
- Reset:
  - Asynchronous on reset=0.
  - hi=0, lo=0, busy=0, internal counter=0, pending result registers=0.
  - Takes effect mid-operation: the in-flight result is discarded and HI/LO are not updated.
- Idle state (busy=0):
  - start=1 with md_op in 1..4: a/b are sampled at that edge and the result is computed into pending registers. The counter loads MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4), and busy=1 from that edge.
  - start=1 with md_op=5: HI<=a at that edge, busy stays 0.
  - start=1 with md_op=6: LO<=a at that edge, busy stays 0.
  - start=1 with md_op 0 or 7: no effect.
- Busy state:
  - The counter decrements each edge.
  - On the edge where the counter goes 1->0, HI/LO take the pending result and busy falls. busy is high for exactly N cycles after the start edge.
  - Result is visible on hi/lo/hilo_rd from the same edge that busy falls.
- start while busy=1 is ignored for every md_op. The hazard unit guarantees it does not occur; the unit must still not corrupt state.
- Hazard contract: the stall condition is start&(md_op in 1..4) | busy. This is not generated here; the unit only supplies busy.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI=upper 32 bits, LO=lower 32 bits.
  - MULTU: unsigned 32x32 -> 64; HI=upper 32 bits, LO=lower 32 bits.
  - DIV: signed. LO=quotient truncated toward zero; HI=remainder with the sign of the dividend (a).
  - DIVU: unsigned. LO=quotient, HI=remainder.
  - Divide by zero (b=0, DIV or DIVU): busy still runs DIV_CYCLES; HI/LO keep their prior values.
  - DIV overflow (a=0x80000000, b=0xFFFFFFFF): LO=0x80000000, HI=0.
- hilo_rd is purely combinational on hi/lo/hilo_sel.
  - It shows old HI/LO while busy; correctness of MFHI/MFLO relies on the stall.
- MTHI and a finishing operation cannot coincide, because MT is ignored while busy.

Test Plan:
1. Reset low mid-DIV (2 cycles after start) -> busy=0, hi=lo=0 immediately. After release, hi/lo stay 0 with no late commit.
2. MULT start, a=0xFFFFFFFF, b=0x00000002 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
   - Same operands with MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
3. DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
   - DIVU a=7, b=2 -> lo=3, hi=1.
4. Preload with MTHI a=0x12345678, MTLO a=0x9ABCDEF0 -> hilo_rd=0x12345678 with sel=1 and 0x9ABCDEF0 with sel=2, busy never rises.
   - Then DIV with b=0 -> busy 10 cycles, hi/lo unchanged.
5. During a MULT busy window, pulse start with md_op=5 (a=0xDEAD0000) and with md_op=3 -> both ignored.
   - MULT result commits on schedule, and busy falls after the original 5 cycles.
6. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
   - Back-to-back MULT started the cycle after busy falls -> busy re-asserts for 5 more cycles with correct result.

Source files
------------

// File: rtl/e_muldiv.sv
// Execute-stage multiply/divide unit owning HI/LO.
// Results are computed at launch into pending registers and committed after a fixed latency.
module e_muldiv #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  hilo_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] hilo_rd
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;
    logic              pend_wr_q, pend_wr_d;

    logic [63:0] a_sx, b_sx, prod_s, prod_u;
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div, quot_mag, rem_mag, quot, rem;

    always_comb begin
        a_sx   = {{32{a[31]}}, a};
        b_sx   = {{32{b[31]}}, b};
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, a} * {32'd0, b};
    end

    // Signed divide works on magnitudes so truncation and remainder sign are explicit;
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    always_comb begin
        div_signed = (md_op == OpDiv);
        a_neg      = div_signed & a[31];
        b_neg      = div_signed & b[31];
        a_mag      = a_neg ? (~a + 32'd1) : a;
        b_mag      = b_neg ? (~b + 32'd1) : b;
        b_div      = (b_mag == 32'd0) ? 32'd1 : b_mag;
        quot_mag   = a_mag / b_div;
        rem_mag    = a_mag % b_div;
        quot       = (a_neg ^ b_neg) ? (~quot_mag + 32'd1) : quot_mag;
        rem        = a_neg ? (~rem_mag + 32'd1) : rem_mag;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (md_op)
                        OpMult: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = CntW'(MULT_CYCLES);
                            state_d   = StBusy;
                        end
                        OpMultu: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = CntW'(MULT_CYCLES);
                            state_d   = StBusy;
                        end
                        OpDiv, OpDivu: begin
                            pend_hi_d = rem;
                            pend_lo_d = quot;
                            // Divide by zero still occupies the unit but leaves HI/LO alone.
                            pend_wr_d = (b != 32'd0);
                            cnt_d     = CntW'(DIV_CYCLES);
                            state_d   = StBusy;
                        end
                        OpMthi:  hi_d = a;
                        OpMtlo:  lo_d = a;
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = (state_q == StBusy);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        case (hilo_sel)
            2'd1:    hilo_rd = hi_q;
            2'd2:    hilo_rd = lo_q;
            default: hilo_rd = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_muldiv.sv
// Bench for e_muldiv: behavioural model checked every cycle plus directed literal checks.
module tb_e_muldiv;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a, b;
    logic [1:0]  hilo_sel;
    logic        busy;
    logic [31:0] hi, lo, hilo_rd;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    e_muldiv #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .a       (a),
        .b       (b),
        .hilo_sel(hilo_sel),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .hilo_rd (hilo_rd)
    );

    always #5 clk = ~clk;

    // {HI, LO} by plain 64-bit arithmetic; division by zero yields 0 (caller suppresses commit).
    function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] x,
                                         input logic [31:0] y);
        longint      sx, sy, sq, sr;
        logic [63:0] ux, uy, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = 64'd0;
        case (op)
            3'd1: r = 64'(sx * sy);
            3'd2: r = ux * uy;
            3'd3: if (y != 32'd0) begin
                sq = sx / sy;
                sr = sx % sy;
                r  = {sr[31:0], sq[31:0]};
            end
            3'd4: if (y != 32'd0) r = {32'(ux % uy), 32'(ux / uy)};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pwr;
    int          m_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi  <= 32'd0;
            m_lo  <= 32'd0;
            m_phi <= 32'd0;
            m_plo <= 32'd0;
            m_pwr <= 1'b0;
            m_cnt <= 0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && m_pwr) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
        end else if (start) begin
            if (md_op inside {3'd1, 3'd2}) begin
                {m_phi, m_plo} <= calc(md_op, a, b);
                m_pwr <= 1'b1;
                m_cnt <= MC;
            end else if (md_op inside {3'd3, 3'd4}) begin
                {m_phi, m_plo} <= calc(md_op, a, b);
                m_pwr <= (b != 32'd0);
                m_cnt <= DC;
            end else if (md_op == 3'd5) begin
                m_hi <= a;
            end else if (md_op == 3'd6) begin
                m_lo <= a;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
            chk("model_rd", hilo_rd,
                (hilo_sel == 2'd1) ? m_hi : (hilo_sel == 2'd2) ? m_lo : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        md_op = op;
        a     = x;
        b     = y;
        start = 1'b1;
        step();
        start = 1'b0;
        md_op = 3'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got busy after %0d cycles want idle", n);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input int cyc, input logic [31:0] eh,
                          input logic [31:0] el);
        int n;
        issue(op, x, y);
        chk({name, "_busy"}, {31'd0, busy}, 32'd1);
        wait_idle(n);
        chk({name, "_cycles"}, n, cyc);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        start    = 1'b0;
        md_op    = 3'd0;
        a        = 32'd0;
        b        = 32'd0;
        hilo_sel = 2'd0;
        repeat (2) @(posedge clk);
        #2;
        reset  = 1'b1;
        chk_en = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // Reset during a divide must drop the in-flight result.
        issue(3'd5, 32'h0000_0055, 32'd0);
        chk("t1_mthi", hi, 32'h0000_0055);
        issue(3'd3, 32'd100, 32'd7);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_hi", hi, 32'd0);
        chk("t1_lo", lo, 32'd0);
        #1;
        reset = 1'b1;
        repeat (15) step();
        chk("t1_late_busy", {31'd0, busy}, 32'd0);
        chk("t1_late_hi", hi, 32'd0);
        chk("t1_late_lo", lo, 32'd0);

        hilo_sel = 2'd1;
        run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        hilo_sel = 2'd2;
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, MC, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        hilo_sel = 2'd1;
        run_op("divu", 3'd4, 32'd7, 32'd2, DC, 32'd1, 32'd3);
        run_op("divs_neg_b", 3'd3, 32'd7, 32'hFFFF_FFFE, DC, 32'd1, 32'hFFFF_FFFD);

        issue(3'd5, 32'h1234_5678, 32'd0);
        chk("t4_mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'h9ABC_DEF0, 32'd0);
        chk("t4_mtlo_busy", {31'd0, busy}, 32'd0);
        hilo_sel = 2'd1;
        #1 chk("t4_rd_hi", hilo_rd, 32'h1234_5678);
        step();
        hilo_sel = 2'd2;
        #1 chk("t4_rd_lo", hilo_rd, 32'h9ABC_DEF0);
        step();
        hilo_sel = 2'd0;
        #1 chk("t4_rd_sel0", hilo_rd, 32'd0);
        step();
        hilo_sel = 2'd3;
        #1 chk("t4_rd_sel3", hilo_rd, 32'd0);
        step();
        chk("t4_busy", {31'd0, busy}, 32'd0);
        run_op("div0", 3'd3, 32'd5, 32'd0, DC, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op("divu0", 3'd4, 32'd9, 32'd0, DC, 32'h1234_5678, 32'h9ABC_DEF0);

        // Starts while busy are ignored; MULT keeps its own operands and schedule.
        hilo_sel = 2'd1;
        issue(3'd1, 32'd3, 32'd4);
        md_op = 3'd5;
        a     = 32'hDEAD_0000;
        start = 1'b1;
        step();
        n     = 1;
        md_op = 3'd3;
        a     = 32'd50;
        b     = 32'd5;
        step();
        n++;
        start = 1'b0;
        md_op = 3'd0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk("t5_cycles", n, MC);
        chk("t5_hi", hi, 32'd0);
        chk("t5_lo", lo, 32'd12);
        step();
        chk("t5_no_div", {31'd0, busy}, 32'd0);

        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000);
        run_op("b2b_mult", 3'd1, 32'h0001_0000, 32'h0001_0000, MC, 32'd1, 32'd0);
        run_op("mult_neg", 3'd1, 32'h8000_0000, 32'h8000_0000, MC, 32'h4000_0000, 32'd0);

        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
